// File: rtl/maze_path_player.sv
// maze_path_player: stores the solved maze path as 2-bit direction codes
// and replays it on a ready/valid move stream while tracking the x/y position.
module maze_path_player #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int COORD_W = 4,
  parameter int START_X = 0,
  parameter int START_Y = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               push,
  input  logic [1:0]         dir_in,
  input  logic               read_en,
  input  logic               move_ready,
  output logic               move_valid,
  output logic [1:0]         move_dir,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               finished_reading,
  output logic [AW:0]        count,
  output logic               empty,
  output logic               full,
  output logic               wr_err
);

  typedef enum logic [1:0] {IDLE, PLAY, FIN} state_t;

  localparam logic [COORD_W-1:0] SX = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] SY = COORD_W'(START_Y);

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic          idle, push_ok, push_drop, accept, last;

  assign idle      = (state == IDLE);
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign push_ok   = push & ~clear & idle & ~full;
  assign push_drop = push & ~clear & (~idle | full);
  assign accept    = move_valid & move_ready;
  assign last      = ({1'b0, rd_ptr} == (count - (AW+1)'(1)));

  // Presented move is read straight out of the array; zero outside playback.
  assign move_dir  = (state == PLAY) ? mem[rd_ptr] : 2'b00;

  // Path storage: append at the current count; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[count[AW-1:0]] <= dir_in;
  end

  // Playback FSM, write count, sticky error and position tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      count            <= '0;
      rd_ptr           <= '0;
      wr_err           <= 1'b0;
      x_out            <= SX;
      y_out            <= SY;
      move_valid       <= 1'b0;
      finished_reading <= 1'b0;
    end else if (clear) begin
      state            <= IDLE;
      count            <= '0;
      rd_ptr           <= '0;
      wr_err           <= 1'b0;
      x_out            <= SX;
      y_out            <= SY;
      move_valid       <= 1'b0;
      finished_reading <= 1'b0;
    end else begin
      if (push_ok)   count  <= count + (AW+1)'(1);
      if (push_drop) wr_err <= 1'b1;
      finished_reading <= 1'b0;
      case (state)
        IDLE: begin
          if (read_en) begin
            if (!empty) begin
              state      <= PLAY;
              move_valid <= 1'b1;
              rd_ptr     <= '0;
              x_out      <= SX;
              y_out      <= SY;
            end else begin
              state            <= FIN;
              finished_reading <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (accept) begin
            // Position moves with wrap-around; the accept always completes
            // even if the request drops in the same cycle.
            case (move_dir)
              2'b00:   y_out <= y_out - COORD_W'(1);
              2'b01:   x_out <= x_out + COORD_W'(1);
              2'b10:   x_out <= x_out - COORD_W'(1);
              default: y_out <= y_out + COORD_W'(1);
            endcase
            rd_ptr <= rd_ptr + AW'(1);
            if (last) begin
              state            <= FIN;
              move_valid       <= 1'b0;
              finished_reading <= 1'b1;
            end else if (!read_en) begin
              state      <= IDLE;
              move_valid <= 1'b0;
            end
          end else if (!read_en) begin
            state      <= IDLE;
            move_valid <= 1'b0;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_path_player.sv
// Bench for maze_path_player: path-list reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_maze_path_player;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int CW    = 4;

  logic clk = 0, rst = 1, clear = 0, push = 0, read_en = 0, move_ready = 0;
  logic [1:0] dir_in = 0;
  logic move_valid, finished_reading, empty, full, wr_err;
  logic [1:0] move_dir;
  logic [CW-1:0] x_out, y_out;
  logic [AW:0] count;

  int n_cmp = 0, n_bad = 0;
  int fin_at;

  always #5 clk = ~clk;

  maze_path_player #(.DEPTH(DEPTH), .AW(AW), .COORD_W(CW), .START_X(0), .START_Y(0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .dir_in(dir_in),
    .read_en(read_en), .move_ready(move_ready), .move_valid(move_valid),
    .move_dir(move_dir), .x_out(x_out), .y_out(y_out),
    .finished_reading(finished_reading), .count(count), .empty(empty),
    .full(full), .wr_err(wr_err));

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: the path is a list, playback is "current index into it".
  int path[$];
  bit m_play, m_fin, m_err, m_idle;
  int m_idx, m_x, m_y, m_n;

  function automatic void step_pos(int d);
    case (d)
      0:       m_y = (m_y + 15) % 16;
      1:       m_x = (m_x + 1) % 16;
      2:       m_x = (m_x + 15) % 16;
      default: m_y = (m_y + 1) % 16;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      path.delete();
      m_play = 0; m_fin = 0; m_err = 0; m_idx = 0; m_x = 0; m_y = 0;
    end else begin
      m_n    = path.size();
      m_idle = !m_play && !m_fin;
      if (push) begin
        if (m_idle && m_n < DEPTH) path.push_back(int'(dir_in));
        else m_err = 1;
      end
      if (m_fin) m_fin = 0;
      else if (m_play) begin
        if (move_ready) begin
          step_pos(path[m_idx]);
          if (m_idx == m_n - 1) begin
            m_play = 0; m_fin = 1;
          end else begin
            m_idx++;
            if (!read_en) m_play = 0;
          end
        end else if (!read_en) m_play = 0;
      end else if (read_en) begin
        if (m_n > 0) begin
          m_play = 1; m_idx = 0; m_x = 0; m_y = 0;
        end else m_fin = 1;
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("move_valid", move_valid, m_play);
      chk("move_dir", move_dir, m_play ? path[m_idx] : 0);
      chk("x_out", x_out, m_x);
      chk("y_out", y_out, m_y);
      chk("finished_reading", finished_reading, m_fin);
      chk("count", count, path.size());
      chk("empty", empty, path.size() == 0);
      chk("full", full, path.size() == DEPTH);
      chk("wr_err", wr_err, m_err);
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push_code(input int d);
    push = 1; dir_in = 2'(d); tick; push = 0;
  endtask

  task automatic do_clear;
    clear = 1; tick; clear = 0;
  endtask

  initial begin
    tick; tick;
    rst = 0;
    // reset state
    chk("rst_valid", move_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_xy", {x_out, y_out}, 0);
    chk("rst_dir", move_dir, 0);

    // basic replay: 01,01,11,11
    push_code(1); push_code(1); push_code(3); push_code(3);
    move_ready = 1; read_en = 1; fin_at = 0;
    for (int c = 1; c <= 10 && fin_at == 0; c++) begin
      tick;
      if (c == 1) begin chk("b_dir1", move_dir, 1); chk("b_xy1", {x_out, y_out}, {4'd0, 4'd0}); end
      if (c == 2) begin chk("b_dir2", move_dir, 1); chk("b_xy2", {x_out, y_out}, {4'd1, 4'd0}); end
      if (c == 3) begin chk("b_dir3", move_dir, 3); chk("b_xy3", {x_out, y_out}, {4'd2, 4'd0}); end
      if (c == 4) begin chk("b_dir4", move_dir, 3); chk("b_xy4", {x_out, y_out}, {4'd2, 4'd1}); end
      if (finished_reading) fin_at = c;
    end
    chk("b_fin_cycle", fin_at, 5);
    chk("b_final_xy", {x_out, y_out}, {4'd2, 4'd2});
    read_en = 0; tick;
    chk("b_fin_one_cycle", finished_reading, 0);

    // backpressure: ready low for 3 cycles during move 2
    read_en = 1; move_ready = 1; fin_at = 0;
    for (int c = 1; c <= 14 && fin_at == 0; c++) begin
      tick;
      move_ready = !(c >= 2 && c <= 4);
      if (c >= 2 && c <= 5) begin
        chk("bp_hold_dir", move_dir, 1);
        chk("bp_hold_xy", {x_out, y_out}, {4'd1, 4'd0});
        chk("bp_hold_valid", move_valid, 1);
      end
      if (finished_reading) fin_at = c;
    end
    chk("bp_fin_cycle", fin_at, 8);
    chk("bp_final_xy", {x_out, y_out}, {4'd2, 4'd2});
    read_en = 0; move_ready = 1; tick;

    // empty request, then two back-to-back replays of a 2-move path
    do_clear;
    read_en = 1; tick;
    chk("e_fin", finished_reading, 1);
    chk("e_novalid", move_valid, 0);
    read_en = 0; tick;
    push_code(1); push_code(3);
    read_en = 1;
    tick; chk("r_dir1", move_dir, 1);
    tick; chk("r_xy2", {x_out, y_out}, {4'd1, 4'd0});
    tick; chk("r_fin1", finished_reading, 1);
    tick; chk("r_idle_gap", move_valid, 0);
    tick; chk("r_replay_valid", move_valid, 1);
          chk("r_replay_xy", {x_out, y_out}, 0);
    tick; tick; chk("r_fin2", finished_reading, 1);
    read_en = 0; tick;

    // fill to DEPTH, then one extra push
    do_clear;
    for (int i = 0; i < DEPTH; i++) push_code(i % 4);
    chk("f_not_err_yet", wr_err, 0);
    push_code(0);
    chk("f_count", count, 256);
    chk("f_full", full, 1);
    chk("f_wr_err", wr_err, 1);
    read_en = 1; move_ready = 1; fin_at = 0;
    for (int c = 1; c <= 300 && fin_at == 0; c++) begin
      tick;
      if (c == 256) chk("f_last_dir", move_dir, 3);
      if (finished_reading) fin_at = c;
    end
    chk("f_fin_cycle", fin_at, 257);
    read_en = 0; tick;

    // push while playing is dropped; clear resets count and error
    do_clear;
    push_code(1);
    move_ready = 0; read_en = 1; tick;
    push_code(0);
    chk("p_wr_err", wr_err, 1);
    chk("p_count", count, 1);
    read_en = 0; clear = 1; tick; clear = 0;
    chk("c_count", count, 0);
    chk("c_wr_err", wr_err, 0);
    chk("c_valid", move_valid, 0);

    // wrap: left from x=0
    push_code(2);
    move_ready = 1; read_en = 1;
    tick; chk("w_x0", x_out, 0);
    tick; chk("w_fin", finished_reading, 1);
          chk("w_x15", x_out, 15);
    read_en = 0; tick;

    // abort by dropping read_en mid-play
    do_clear;
    push_code(1); push_code(1); push_code(1);
    move_ready = 0; read_en = 1;
    tick; chk("a_valid", move_valid, 1);
    read_en = 0;
    tick; chk("a_idle", move_valid, 0); chk("a_nopulse", finished_reading, 0);
    tick; chk("a_nopulse2", finished_reading, 0);

    // async reset mid-playback
    move_ready = 1; read_en = 1;
    tick; tick;
    #2 rst = 1;
    #1;
    chk("ar_valid", move_valid, 0);
    chk("ar_dir", move_dir, 0);
    chk("ar_xy", {x_out, y_out}, 0);
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_fin", finished_reading, 0);
    read_en = 0; move_ready = 0;
    tick; rst = 0;

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      clear      = ($urandom_range(0, 299) == 0);
      push       = ($urandom_range(0, 3) == 0);
      dir_in     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) read_en = !read_en;
      move_ready = ($urandom_range(0, 9) < 7);
      tick;
    end
    clear = 0; push = 0; read_en = 0;
    tick; tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/maze_path_player.md
# maze_path_player

Path storage and playback unit for the maze solver. After a successful solve, the solver pushes the path one direction code at a time (start move first). While a run is requested, this block replays the stored path step by step on a ready/valid move stream, tracking the mouse's x/y position. It signals completion back to the solver with a one-cycle `finished_reading` pulse. Playback is non-destructive, so the path can be replayed any number of times.

## Interface
- `DEPTH`, 256: maximum number of stored moves; power of two.
- `AW`, 8: address width, log2(DEPTH).
- `COORD_W`, 4: x/y coordinate width.
- `START_X`, 0: x coordinate at the start of every playback.
- `START_Y`, 0: y coordinate at the start of every playback.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous path clear; priority over all other inputs except `rst`.
- `push` in 1: append `dir_in` to the path.
- `dir_in` in 2: direction code: 00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1).
- `read_en` in 1: level request to play the path (driven from the solver's read_checkList).
- `move_ready` in 1: downstream accepts the current move.
- `move_valid` out 1: a move is presented.
- `move_dir` out 2: direction of the presented move.
- `x_out` out COORD_W: current x position (before the presented move).
- `y_out` out COORD_W: current y position (before the presented move).
- `finished_reading` out 1: one-cycle pulse when playback completes.
- `count` out AW+1: number of stored moves.
- `empty` out 1: `count == 0`.
- `full` out 1: `count == DEPTH`.
- `wr_err` out 1: sticky flag for a dropped push.

## Operation
- **Storage.** DEPTH×2 register array plus write count. A push in IDLE with `~full` writes `mem[count]` and increments `count`.
- **Dropped pushes.** A push while full, or while not in IDLE, is dropped and sets `wr_err`. `wr_err` is cleared only by `clear` or `rst`.
- **clear.** Sets `count=0`, `wr_err=0`, state to IDLE, and `x_out`/`y_out` to START. Any playback in progress is abandoned without a `finished_reading` pulse.
- **FSM states:** IDLE, PLAY, FIN.
- **IDLE:**
  - `read_en & ~empty` → PLAY, with `rd_ptr=0`, `x_out=START_X`, `y_out=START_Y`.
  - `read_en & empty` → FIN.
  - Otherwise stay in IDLE.
- **PLAY:**
  - `move_valid=1` and `move_dir=mem[rd_ptr]`.
  - On accept (`move_valid & move_ready`), update x/y per `dir_in` encoding, modulo 2^COORD_W (wrap, no saturation), and increment `rd_ptr`.
  - Accept with `rd_ptr==count-1` → FIN.
  - `read_en` low with no accept in the same cycle → IDLE (abort, no pulse); position is held.
  - An accept and a `read_en` drop in the same cycle: the accept completes first, then abort.
- **FIN:** `finished_reading=1` for exactly one cycle, then IDLE.
  - If `read_en` is still high, IDLE restarts playback on the next cycle. This replay matches the solver, which re-requests while `run` is held.
- **`move_dir` when not in PLAY:** 00.

## Timing
- **Reset values** (`rst` asserted, async): state IDLE, `count=0`, `rd_ptr=0`, `wr_err=0`, `x_out=START_X`, `y_out=START_Y`, `move_valid=0`, `move_dir=00`, `finished_reading=0`, `empty=1`, `full=0`. Memory contents are don't-care.
- **Start latency:** `read_en` sampled high in IDLE → `move_valid` high the next cycle.
- **Throughput:** one move per cycle while `move_ready` is held high.
- **Playback of N moves with `move_ready=1`:** `read_en` edge at cycle 0, moves at cycles 1..N, `finished_reading` at cycle N+1, IDLE at N+2.
- **Output timing:**
  - `move_valid`, `finished_reading`, `x_out` and `y_out` come straight from registered state.
  - `move_dir` is a combinational read of the array at `rd_ptr`.
  - `count`, `empty`, `full` and `wr_err` update the cycle after the push or clear.
- **Hold rule:** while `move_valid & ~move_ready`, `move_dir`, `x_out` and `y_out` remain stable.
- **Reset mid-playback:** immediate return to the reset values; no pulse.

## Test plan
- **Basic replay.** Reset, then push 01,01,11,11 and raise `read_en` with `move_ready=1`. Required: `move_dir` = 01,01,11,11 on 4 consecutive cycles, with (x,y) = (0,0),(1,0),(2,0),(2,1) presented and final position (2,2). `finished_reading` is high for 1 cycle at cycle 5.
- **Backpressure.** Same path, with `move_ready` low for 3 cycles during move 2. Required: `move_dir=01` and (1,0) are held stable, no move is skipped, and `finished_reading` arrives 3 cycles later than in the basic case.
- **Empty and replay.** `read_en` with `count=0` produces a `finished_reading` pulse 1 cycle later with no `move_valid`. Holding `read_en` over a 2-move path gives two complete replays, each starting at (0,0).
- **Full and push rules.** Push 256 times, then once more. Required: `count=256`, `full=1`, `wr_err=1`, and the 257th code is not stored. A push during PLAY also sets `wr_err`; `clear` gives `count=0` and `wr_err=0`.
- **Wrap and abort.** Push 10 (left) from START (0,0) → `x_out=15`. Dropping `read_en` mid-PLAY returns to IDLE with no pulse; async `rst` mid-PLAY forces every output to its reset value immediately.
